// File: rtl/spike_pkg.sv
`default_nettype none
// ============================================================================
// Package     : spike_pkg
// Description : Shared types and default sizing for the spike output arbiter.
//               Holds the event record carried on the merged spike stream.
// Revision    : 1.0 - initial release
// ============================================================================
package spike_pkg;

  localparam int c_n_neurons  = 8;
  localparam int c_time_width = 16;
  localparam int c_drop_width = 8;
  localparam int c_addr_width = $clog2(c_n_neurons);

  // One merged output event at the default sizing.
  typedef struct packed {
    logic [c_addr_width-1:0] addr;
    logic                    on_off;
    logic [c_time_width-1:0] time_stamp;
  } spike_event_t;

endpackage
`default_nettype wire

// File: rtl/spike_out_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface   : spike_out_arbiter_if
// Description : Bundles the neuron spike inputs and the merged event output
//               stream (valid/ready) of spike_out_arbiter.
//   spike_valid  - per-neuron one-cycle spike pulse
//   spike_on_off - per-neuron flag (1 = threshold spike, 0 = end of refractory)
//   out_valid / out_ready - event handshake
//   out_addr, out_on_off, out_time - event payload
//   overflow     - sticky "event dropped" flag
//   drop_count   - saturating drop counter (only when SPIKE_ARB_DROP_CNT_EN)
// Modports    : master = arbiter side, slave = consumer / neuron driver side
// Revision    : 1.0 - initial release
// ============================================================================
interface spike_out_arbiter_if
  import spike_pkg::*;
#(
  parameter int N_NEURONS  = c_n_neurons,
  parameter int ADDR_WIDTH = $clog2(N_NEURONS),
  parameter int TIME_WIDTH = c_time_width
`ifdef SPIKE_ARB_DROP_CNT_EN
  , parameter int DROP_WIDTH = c_drop_width
`endif
);

  logic [N_NEURONS-1:0]  spike_valid;
  logic [N_NEURONS-1:0]  spike_on_off;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  out_on_off;
  logic [TIME_WIDTH-1:0] out_time;
  logic                  overflow;
`ifdef SPIKE_ARB_DROP_CNT_EN
  logic [DROP_WIDTH-1:0] drop_count;
`endif

  modport master (
    input  spike_valid, spike_on_off, out_ready,
`ifdef SPIKE_ARB_DROP_CNT_EN
    output drop_count,
`endif
    output out_valid, out_addr, out_on_off, out_time, overflow
  );

  modport slave (
    output spike_valid, spike_on_off, out_ready,
`ifdef SPIKE_ARB_DROP_CNT_EN
    input  drop_count,
`endif
    input  out_valid, out_addr, out_on_off, out_time, overflow
  );

endinterface
`default_nettype wire

// File: rtl/spike_out_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker. Selects the first asserted
//               request at or after the pointer, wrapping modulo N.
//   i_req   - request mask
//   i_ptr   - round-robin start index
//   o_grant - one-hot grant (zero when no request)
//   o_idx   - index of granted request
//   o_any   - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N  = 8,
  parameter int AW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [AW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [AW-1:0] o_idx,
  output logic          o_any
);

  always_comb begin : comb_pick
    logic [AW:0]   v_sum;
    logic [AW-1:0] v_idx;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    v_sum   = '0;
    v_idx   = '0;
    for (int k = 0; k < N; k++) begin
      // Candidate index = (ptr + k) mod N, computed one bit wider to catch wrap.
      v_sum = {1'b0, i_ptr} + (AW+1)'(k);
      if (v_sum >= (AW+1)'(N)) begin
        v_sum = v_sum - (AW+1)'(N);
      end
      v_idx = v_sum[AW-1:0];
      if (!o_any && i_req[v_idx]) begin
        o_any          = 1'b1;
        o_grant[v_idx] = 1'b1;
        o_idx          = v_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spike_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spike_out_arbiter
// Description : Captures one-cycle spike pulses from N_NEURONS sources into
//               one pending slot per neuron and merges them round-robin onto a
//               single registered valid/ready event stream carrying the
//               neuron address, on/off flag and arrival timestamp.
//   clk   - system clock
//   reset - synchronous, active-low reset
//   bus   - spike_out_arbiter_if.master (spike inputs, event output stream,
//           overflow, and drop_count when SPIKE_ARB_DROP_CNT_EN is defined)
// Config      : `define SPIKE_ARB_DROP_CNT_EN adds the saturating drop counter.
// Revision    : 1.0 - initial release
// ============================================================================
module spike_out_arbiter
  import spike_pkg::*;
#(
  parameter int N_NEURONS  = c_n_neurons,
  parameter int ADDR_WIDTH = $clog2(N_NEURONS),
  parameter int TIME_WIDTH = c_time_width
`ifdef SPIKE_ARB_DROP_CNT_EN
  , parameter int DROP_WIDTH = c_drop_width
`endif
) (
  input  logic                       clk,
  input  logic                       reset,
  spike_out_arbiter_if.master        bus
);

  // Pending slots, one per neuron.
  logic [N_NEURONS-1:0]  r_full;
  logic [N_NEURONS-1:0]  r_on;
  logic [TIME_WIDTH-1:0] r_ts [N_NEURONS];

  logic [TIME_WIDTH-1:0] r_time;
  logic [ADDR_WIDTH-1:0] r_ptr;

  // Output register.
  logic                  r_out_valid;
  logic [ADDR_WIDTH-1:0] r_out_addr;
  logic                  r_out_on_off;
  logic [TIME_WIDTH-1:0] r_out_time;
  logic                  r_overflow;

  logic                  w_load;
  logic [N_NEURONS-1:0]  w_arb_grant;
  logic [N_NEURONS-1:0]  w_grant;
  logic [N_NEURONS-1:0]  w_drop;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_any;
  logic                  w_win;
  logic [ADDR_WIDTH-1:0] w_ptr_next;

  assign w_load = !r_out_valid || bus.out_ready;

  rr_arbiter #(
    .N  (N_NEURONS),
    .AW (ADDR_WIDTH)
  ) u_rr_arbiter (
    .i_req   (r_full),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_win   = w_load && w_any;
  assign w_grant = w_load ? w_arb_grant : '0;
  // A slot being granted this cycle is free for a new pulse; otherwise the
  // stored (older) event wins and the new one is lost.
  assign w_drop  = bus.spike_valid & r_full & ~w_grant;
  assign w_ptr_next = (w_idx == ADDR_WIDTH'(N_NEURONS-1)) ? '0 : w_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_full <= '0;
      r_on   <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        r_ts[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_NEURONS; i++) begin
        if (bus.spike_valid[i] && (!r_full[i] || w_grant[i])) begin
          r_full[i] <= 1'b1;
          r_on[i]   <= bus.spike_on_off[i];
          r_ts[i]   <= r_time;
        end else if (w_grant[i]) begin
          r_full[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_time       <= '0;
      r_ptr        <= '0;
      r_out_valid  <= 1'b0;
      r_out_addr   <= '0;
      r_out_on_off <= 1'b0;
      r_out_time   <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_time <= r_time + 1'b1;
      if (|w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_win) begin
        r_out_valid  <= 1'b1;
        r_out_addr   <= w_idx;
        r_out_on_off <= r_on[w_idx];
        r_out_time   <= r_ts[w_idx];
        r_ptr        <= w_ptr_next;
      end else if (w_load) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef SPIKE_ARB_DROP_CNT_EN
  logic [DROP_WIDTH-1:0] r_drop_count;
  logic [DROP_WIDTH:0]   w_drop_sum;

  // Several neurons may drop in the same cycle; each one counts.
  always_comb begin
    w_drop_sum = {1'b0, r_drop_count};
    for (int i = 0; i < N_NEURONS; i++) begin
      w_drop_sum = w_drop_sum + (DROP_WIDTH+1)'(w_drop[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_drop_count <= '0;
    end else if (w_drop_sum[DROP_WIDTH]) begin
      r_drop_count <= '1;
    end else begin
      r_drop_count <= w_drop_sum[DROP_WIDTH-1:0];
    end
  end

  assign bus.drop_count = r_drop_count;
`endif

  assign bus.out_valid  = r_out_valid;
  assign bus.out_addr   = r_out_addr;
  assign bus.out_on_off = r_out_on_off;
  assign bus.out_time   = r_out_time;
  assign bus.overflow   = r_overflow;

endmodule
`default_nettype wire
